// File: rtl/matrix_ops_pkg.sv
// Shared types and helpers for the matrix_ops library: FSM state encoding,
// accumulator sizing and flat-bus element indexing.
package matrix_ops_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Worst-case product sum: 2*dw bits per product plus growth for w terms and a sign bit.
  function automatic int acc_width(input int dw, input int w);
    return 2 * dw + $clog2(w) + 1;
  endfunction

  function automatic int unsigned mat_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned w);
    return r * w + c;
  endfunction

  function automatic int unsigned vec_idx(input int unsigned c);
    return c;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// Single multiply-accumulate lane: extends both operands to ACC_WIDTH
// (sign or zero) and accumulates their exact product.
module mac_lane
  import matrix_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  signed_mode,
  input  logic                  clear,
  input  logic                  enable,
  output logic [ACC_WIDTH-1:0]  sum
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] a_ext, b_ext, prod;

  // Low ACC_WIDTH bits of the product of extended operands are exact for both modes.
  always_comb begin
    a_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & a[DATA_WIDTH-1]}}, a};
    b_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_mode & b[DATA_WIDTH-1]}}, b};
    prod  = a_ext * b_ext;
    sum   = acc_q + prod;
  end

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_vector_mac.sv
// Sequential matrix x vector multiplier: operands captured on i_calc, result
// built column by column on LANES MAC lanes, one row group at a time.
module matrix_vector_mac
  import matrix_ops_pkg::*;
#(
  parameter int MATRIX_WIDTH  = 2,
  parameter int MATRIX_HEIGHT = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 1,
  localparam int ACC_WIDTH    = acc_width(DATA_WIDTH, MATRIX_WIDTH)
) (
  input  logic                                        clk,
  input  logic                                        i_rst,
  input  logic                                        i_calc,
  input  logic                                        i_signed,
  input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] i_matrix,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]          i_vector,
  output logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]          o_result,
  output logic                                        o_busy,
  output logic                                        o_ready
);

  localparam int GROUPS = MATRIX_HEIGHT / LANES;
  localparam int CW     = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

  if (MATRIX_HEIGHT % LANES != 0) begin : g_bad_lanes
    $error("matrix_vector_mac: LANES must divide MATRIX_HEIGHT");
  end

  state_e                                          state_q, state_d;
  logic [CW-1:0]                                   col_q, col_d;
  logic [GW-1:0]                                   grp_q, grp_d;
  logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] mat_q, mat_d;
  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]              vec_q, vec_d;
  logic                                            signed_q, signed_d;
  logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]              buf_q, buf_d;
  logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]              result_q, result_d;

  logic                  acc_clear, acc_en;
  logic [DATA_WIDTH-1:0] vec_elem;
  logic [DATA_WIDTH-1:0] lane_a   [LANES];
  logic [ACC_WIDTH-1:0]  lane_sum [LANES];

  assign vec_elem = vec_q[vec_idx(32'(col_q))*DATA_WIDTH +: DATA_WIDTH];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_a[l] =
      mat_q[mat_idx(32'(grp_q)*LANES + l, 32'(col_q), MATRIX_WIDTH)*DATA_WIDTH +: DATA_WIDTH];

    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk        (clk),
      .i_rst      (i_rst),
      .a          (lane_a[l]),
      .b          (vec_elem),
      .signed_mode(signed_q),
      .clear      (acc_clear),
      .enable     (acc_en),
      .sum        (lane_sum[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    grp_d     = grp_q;
    mat_d     = mat_q;
    vec_d     = vec_q;
    signed_d  = signed_q;
    buf_d     = buf_q;
    result_d  = result_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_calc) begin
          state_d   = RUN;
          mat_d     = i_matrix;
          vec_d     = i_vector;
          signed_d  = i_signed;
          col_d     = '0;
          grp_d     = '0;
          acc_clear = 1'b1;
        end
      end
      RUN: begin
        acc_en = 1'b1;
        if (col_q == COL_LAST) begin
          acc_clear = 1'b1;
          col_d     = '0;
          for (int unsigned l = 0; l < LANES; l++) begin
            buf_d[(32'(grp_q)*LANES + l)*ACC_WIDTH +: ACC_WIDTH] = lane_sum[l];
          end
          // o_result is loaded on the edge into DONE so it is valid alongside o_ready.
          if (grp_q == GRP_LAST) begin
            state_d  = DONE;
            result_d = buf_d;
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      grp_q    <= '0;
      mat_q    <= '0;
      vec_q    <= '0;
      signed_q <= 1'b0;
      buf_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      grp_q    <= grp_d;
      mat_q    <= mat_d;
      vec_q    <= vec_d;
      signed_q <= signed_d;
      buf_q    <= buf_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;
  assign o_busy   = (state_q != IDLE);
  assign o_ready  = (state_q == DONE);

endmodule

// File: tb/tb_matrix_vector_mac.sv
// Scoreboard bench for matrix_vector_mac: default 2x2 instance plus a LANES=2 instance.
module tb_matrix_vector_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calc1 = 1'b0;
  logic        calc2 = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] mat = '0;
  logic [15:0] vec = '0;
  logic [35:0] res1, res2;
  logic        busy1, busy2, rdy1, rdy2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [35:0] q1[$];
  logic [35:0] q2[$];
  int          lat1[$];
  int          lat2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  matrix_vector_mac dut1 (
    .clk(clk), .i_rst(rst), .i_calc(calc1), .i_signed(sgn),
    .i_matrix(mat), .i_vector(vec),
    .o_result(res1), .o_busy(busy1), .o_ready(rdy1)
  );

  matrix_vector_mac #(.LANES(2)) dut2 (
    .clk(clk), .i_rst(rst), .i_calc(calc2), .i_signed(sgn),
    .i_matrix(mat), .i_vector(vec),
    .o_result(res2), .o_busy(busy2), .o_ready(rdy2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop an expectation on every o_ready and compare result and edge count.
  always @(negedge clk) begin
    if (rdy1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_ready", 64'(rdy1), 64'(0));
      end else begin
        check("dut1_result", 64'(res1), 64'(q1.pop_front()));
        check("dut1_latency", 64'(cyc), 64'(lat1.pop_front()));
      end
    end
    if (rdy2) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_ready", 64'(rdy2), 64'(0));
      end else begin
        check("dut2_result", 64'(res2), 64'(q2.pop_front()));
        check("dut2_latency", 64'(cyc), 64'(lat2.pop_front()));
      end
    end
  end

  // Accept edge is cyc+1; DONE is observed after G*MATRIX_WIDTH further edges.
  task automatic issue(input logic [31:0] m, input logic [15:0] v, input logic s,
                       input logic [35:0] exp, input bit use2);
    @(negedge clk);
    mat = m;
    vec = v;
    sgn = s;
    calc1 = 1'b1;
    q1.push_back(exp);
    lat1.push_back(cyc + 1 + 4);
    if (use2) begin
      calc2 = 1'b1;
      q2.push_back(exp);
      lat2.push_back(cyc + 1 + 2);
    end
    @(negedge clk);
    calc1 = 1'b0;
    calc2 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q1.size() == 0 && q2.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", 64'(q1.size() + q2.size()), 64'(0));
    q1.delete();
    q2.delete();
    lat1.delete();
    lat2.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_result1", 64'(res1), 64'(0));
    check("reset_result2", 64'(res2), 64'(0));
    check("reset_busy", 64'({busy1, busy2}), 64'(0));
    check("reset_ready", 64'({rdy1, rdy2}), 64'(0));
    rst = 1'b0;

    // m00=14 m01=6 m10=3 m11=2, v0=14 v1=10 -> r0=256 r1=62
    issue({8'd2, 8'd3, 8'd6, 8'd14}, {8'd10, 8'd14}, 1'b0, {18'd62, 18'd256}, 1'b1);
    check("busy_after_accept", 64'({busy1, busy2}), 64'(3));
    drain();

    // (-1)*(-128)*2 = 256 signed; 255*128*2 = 65280 unsigned
    issue(32'hFFFF_FFFF, 16'h8080, 1'b1, {18'd256, 18'd256}, 1'b0);
    drain();
    issue(32'hFFFF_FFFF, 16'h8080, 1'b0, {18'd65280, 18'd65280}, 1'b0);
    drain();

    // 255*255*2 = 130050 fits in 18 bits
    issue(32'hFFFF_FFFF, 16'hFFFF, 1'b0, {18'd130050, 18'd130050}, 1'b0);
    drain();

    // Restart strobe and operand changes during RUN are ignored; o_result holds.
    issue({8'd2, 8'd3, 8'd6, 8'd14}, {8'd10, 8'd14}, 1'b0, {18'd62, 18'd256}, 1'b0);
    check("hold_run_c1", 64'(res1), 64'({18'd130050, 18'd130050}));
    mat = 32'h0102_0304;
    vec = 16'h0506;
    sgn = 1'b1;
    calc1 = 1'b1;
    @(negedge clk);
    check("hold_run_c2", 64'(res1), 64'({18'd130050, 18'd130050}));
    calc1 = 1'b0;
    @(negedge clk);
    check("hold_run_c3", 64'(res1), 64'({18'd130050, 18'd130050}));
    drain();
    repeat (8) @(negedge clk);

    // Reset in 2nd RUN cycle aborts the job without an o_ready.
    issue(32'hFFFF_FFFF, 16'hFFFF, 1'b0, {18'd130050, 18'd130050}, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q1.delete();
    lat1.delete();
    @(negedge clk);
    check("midrun_rst_busy", 64'(busy1), 64'(0));
    check("midrun_rst_result", 64'(res1), 64'(0));
    check("midrun_rst_ready", 64'(rdy1), 64'(0));
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue({8'd2, 8'd3, 8'd6, 8'd14}, {8'd10, 8'd14}, 1'b0, {18'd62, 18'd256}, 1'b0);
    drain();

    // Reset and start in the same cycle: start is dropped.
    @(negedge clk);
    rst = 1'b1;
    calc1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    calc1 = 1'b0;
    check("rst_calc_busy", 64'(busy1), 64'(0));
    check("rst_calc_result", 64'(res1), 64'(0));
    repeat (8) @(negedge clk);
    check("final_queue_empty", 64'(q1.size() + q2.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
